axi4_lite_csr_master: RTL and testbench

- AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write or read transactions on an axi4_lite_if master port.
- Its counterpart is the CSR slave used by csi2_rx. Sensor/PHY bring-up sequencers and the SCCB config engine use it to program and poll CSI-2 receiver registers.
- One transaction is outstanding at a time. The response is returned on a valid/ready response port.

---
 rtl/axi4_lite_csr_master_pkg.sv | 18 +
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/axi4_lite_wdt.sv | 29 ++
 rtl/axi4_lite_csr_master.sv | 185 ++++++++++++++++++
 tb/tb_axi4_lite_csr_master.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_csr_master_pkg.sv
// Shared types for the AXI4-Lite CSR initiator: FSM state encoding and AXI response codes.
package axi4_lite_csr_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_wdt.sv
// Transaction watchdog: counts enabled cycles since the last clear, flags expiry at LIMIT-1.
// Only built with AXI4_LITE_CSR_MASTER_TIMEOUT_EN; expiry is combinational from the count register.
`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
module axi4_lite_wdt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator for CSR commands; fast-slave latency 3 cycles accept->rsp.
// Stalls on the AXI side until handshakes and holds rsp until rsp_ready_i; AXI4_LITE_CSR_MASTER_TIMEOUT_EN adds a watchdog.
module axi4_lite_csr_master
  import axi4_lite_csr_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o,
  axi4_lite_if.master             csr_if
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("axi4_lite_csr_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
  end

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic aw_done_q, w_done_q;
  logic rsp_valid_q, rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic cmd_accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done_d, w_done_d;
  logic timeout_hit, timeout_fire;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;

  assign aw_hs     = awvalid_q && csr_if.awready;
  assign w_hs      = wvalid_q && csr_if.wready;
  assign ar_hs     = arvalid_q && csr_if.arready;
  assign b_hs      = bready_q && csr_if.bvalid;
  assign r_hs      = rready_q && csr_if.rvalid;
  assign aw_done_d = aw_done_q || aw_hs;
  assign w_done_d  = w_done_q || w_hs;

  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    unique case (state_q)
      IDLE:    if (cmd_accept) state_d = cmd_write_i ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done_d && w_done_d) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = RESP;
      RD_REQ:  if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A handshake landing on the expiry cycle wins over the watchdog.
    if (timeout_hit && (state_d == state_q)) begin
      state_d      = RESP;
      timeout_fire = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_RESP_OKAY;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        wstrb_q <= cmd_wstrb_i;
        write_q <= cmd_write_i;
      end
      // AW and W retire independently; each valid drops the cycle after its own handshake.
      aw_done_q   <= (state_d == WR_REQ) && aw_done_d;
      w_done_q    <= (state_d == WR_REQ) && w_done_d;
      awvalid_q   <= (state_d == WR_REQ) && !aw_done_d;
      wvalid_q    <= (state_d == WR_REQ) && !w_done_d;
      arvalid_q   <= (state_d == RD_REQ);
      bready_q    <= (state_d == WR_RESP);
      rready_q    <= (state_d == RD_DATA);
      rsp_valid_q <= (state_d == RESP);
      if (b_hs) begin
        rsp_resp_q  <= csr_if.bresp;
        rsp_rdata_q <= '0;
        rsp_write_q <= 1'b1;
      end else if (r_hs) begin
        rsp_resp_q  <= csr_if.rresp;
        rsp_rdata_q <= csr_if.rdata;
        rsp_write_q <= 1'b0;
      end else if (timeout_fire) begin
        rsp_resp_q  <= AXI_RESP_SLVERR;
        rsp_rdata_q <= '0;
        rsp_write_q <= write_q;
      end
    end
  end

`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
  logic wdt_en;
  logic rsp_timeout_q;

  assign wdt_en = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};

  axi4_lite_wdt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (state_d != state_q),
    .en_i      (wdt_en),
    .expired_o (timeout_hit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_timeout_q <= 1'b0;
    end else if (b_hs || r_hs) begin
      rsp_timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      rsp_timeout_q <= 1'b1;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

  assign csr_if.awaddr  = addr_q;
  assign csr_if.awprot  = 3'b000;
  assign csr_if.awvalid = awvalid_q;
  assign csr_if.wdata   = wdata_q;
  assign csr_if.wstrb   = wstrb_q;
  assign csr_if.wvalid  = wvalid_q;
  assign csr_if.bready  = bready_q;
  assign csr_if.araddr  = addr_q;
  assign csr_if.arprot  = 3'b000;
  assign csr_if.arvalid = arvalid_q;
  assign csr_if.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_csr_master.sv
// Randomised bench for axi4_lite_csr_master against a delay-configurable AXI4-Lite slave and a register-file model.
module tb_axi4_lite_csr_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) csr_if ();

  axi4_lite_csr_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .busy_o(busy), .csr_if(csr_if)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation counters.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit ar_block = 0, inject_r = 0;
  int aw_hi, w_hi, ar_hi, aw_hs_n, b_hs_n, r_hs_n, aw_unstable;
  logic [31:0] slv_mem [64];
  logic [31:0] model_mem [64];

  initial begin : slave_model
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w, b_pend, r_pend, spur, prev_hold;
    int aw_wait, w_wait, ar_wait, b_timer, r_timer;
    logic [7:0] aw_a, r_a, prev_awaddr;
    logic [31:0] w_d;
    logic [3:0] w_s;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; spur = 0; prev_hold = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_timer = 0; r_timer = 0;
    aw_a = '0; r_a = '0; prev_awaddr = '0; w_d = '0; w_s = '0;
    csr_if.awready = 0; csr_if.wready = 0; csr_if.arready = 0;
    csr_if.bvalid = 0; csr_if.bresp = 0; csr_if.rvalid = 0; csr_if.rresp = 0; csr_if.rdata = 0;
    forever begin
      @(posedge clk);
      hs_aw = csr_if.awvalid && csr_if.awready;
      hs_w  = csr_if.wvalid && csr_if.wready;
      hs_b  = csr_if.bvalid && csr_if.bready;
      hs_ar = csr_if.arvalid && csr_if.arready;
      hs_r  = csr_if.rvalid && csr_if.rready;
      if (!rst_n) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; prev_hold = 0;
      end else begin
        if (csr_if.awvalid) aw_hi++;
        if (csr_if.wvalid) w_hi++;
        if (csr_if.arvalid) ar_hi++;
        if (prev_hold && csr_if.awvalid && csr_if.awaddr !== prev_awaddr) aw_unstable++;
        prev_hold = csr_if.awvalid && !hs_aw;
        prev_awaddr = csr_if.awaddr;
        if (hs_aw) begin got_aw = 1; aw_a = csr_if.awaddr; aw_hs_n++; end
        if (hs_w) begin got_w = 1; w_d = csr_if.wdata; w_s = csr_if.wstrb; end
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) slv_mem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
          got_aw = 0; got_w = 0; b_pend = 1; b_timer = b_dly;
        end
        if (hs_b) b_hs_n++;
        if (hs_ar) begin r_pend = 1; r_timer = r_dly; r_a = csr_if.araddr; end
        if (hs_r) r_hs_n++;
      end
      #1;
      if (hs_b || !rst_n) csr_if.bvalid = 0;
      if (hs_r || spur || !rst_n) begin csr_if.rvalid = 0; spur = 0; end
      if (inject_r) begin
        csr_if.rvalid = 1; csr_if.rdata = 32'hBAD0_BAD0; csr_if.rresp = 2'b00;
        inject_r = 0; spur = 1;
      end
      if (b_pend) begin
        if (b_timer == 0) begin csr_if.bvalid = 1; csr_if.bresp = bresp_cfg; b_pend = 0; end
        else b_timer--;
      end
      if (r_pend) begin
        if (r_timer == 0) begin
          csr_if.rvalid = 1; csr_if.rdata = slv_mem[r_a[7:2]]; csr_if.rresp = rresp_cfg; r_pend = 0;
        end else r_timer--;
      end
      if (hs_aw) aw_wait = 0;
      if (csr_if.awvalid) begin csr_if.awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin csr_if.awready = 0; aw_wait = 0; end
      if (hs_w) w_wait = 0;
      if (csr_if.wvalid) begin csr_if.wready = (w_wait >= w_dly); w_wait++; end
      else begin csr_if.wready = 0; w_wait = 0; end
      if (hs_ar) ar_wait = 0;
      if (csr_if.arvalid && !ar_block) begin csr_if.arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin csr_if.arready = 0; ar_wait = 0; end
    end
  end

  // One command through the DUT; expectations come from the slave settings and the model register file.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input string tag);
    int lat, exp_lat, waited;
    logic [1:0] exp_resp;
    logic [31:0] exp_rdata;
    bit exp_to;
    if (!wr && ar_block) begin
      exp_lat = TO + 1; exp_resp = 2'b10; exp_rdata = '0; exp_to = 1;
    end else if (wr) begin
      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      exp_resp = bresp_cfg; exp_rdata = '0; exp_to = 0;
    end else begin
      exp_lat = 3 + ar_dly + r_dly; exp_resp = rresp_cfg; exp_rdata = model_mem[addr[7:2]]; exp_to = 0;
    end
    if (wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
    aw_hi = 0; w_hi = 0; ar_hi = 0; aw_hs_n = 0; b_hs_n = 0; r_hs_n = 0; aw_unstable = 0;
    @(negedge clk);
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    check_eq({tag, "_busy"}, busy, 1);
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_rsp_write"}, rsp_write, wr);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, "_rsp_resp"}, rsp_resp, exp_resp);
    check_eq({tag, "_rsp_timeout"}, rsp_timeout, exp_to);
    if (hold > 0) begin
      cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_eq({tag, "_hold_valid"}, rsp_valid, 1);
        check_eq({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, "_hold_resp"}, rsp_resp, exp_resp);
        check_eq({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      end
    end
    rsp_ready = 1;
    check_eq({tag, "_hs_cmd_ready"}, cmd_ready, 0);
    @(negedge clk);
    rsp_ready = 0;
    cmd_valid = 0;
    check_eq({tag, "_post_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_post_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin : global_watchdog
    #400000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin : main
    logic [1:0] resp_tbl [4];
    logic [31:0] v;
    resp_tbl[0] = 2'b00; resp_tbl[1] = 2'b00; resp_tbl[2] = 2'b10; resp_tbl[3] = 2'b11;
    for (int i = 0; i < 64; i++) begin v = $urandom; slv_mem[i] = v; model_mem[i] = v; end

    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_axi_valids", {csr_if.awvalid, csr_if.wvalid, csr_if.arvalid}, 3'b000);
    check_eq("rst_axi_readies", {csr_if.bready, csr_if.rready}, 2'b00);
    check_eq("rst_rsp_payload", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, '0);
    rst_n = 1;

    run_txn(1, 8'h04, 32'h1, 4'hF, 0, "wr_zero_wait");
    check_eq("wr_zero_wait_aw_cycles", aw_hi, 1);
    check_eq("wr_zero_wait_w_cycles", w_hi, 1);
    check_eq("wr_zero_wait_reg1", slv_mem[1], 32'h0000_0001);

    slv_mem[7] = 32'hDEAD_BEEF; model_mem[7] = 32'hDEAD_BEEF;
    run_txn(0, 8'h1C, 32'h0, 4'h0, 0, "rd_zero_wait");

    aw_dly = 3;
    run_txn(1, 8'h20, 32'hA5A5_5A5A, 4'hF, 0, "wr_skew");
    check_eq("wr_skew_aw_cycles", aw_hi, 4);
    check_eq("wr_skew_w_cycles", w_hi, 1);
    check_eq("wr_skew_b_count", b_hs_n, 1);
    check_eq("wr_skew_awaddr_unstable", aw_unstable, 0);
    aw_dly = 0;

    run_txn(0, 8'h20, 32'h0, 4'h0, 5, "rd_backpressure");

    rresp_cfg = 2'b10;
    run_txn(0, 8'h08, 32'h0, 4'h0, 0, "rd_slverr");
    rresp_cfg = 2'b00;

    @(negedge clk);
    inject_r = 1;
    repeat (4) begin
      @(negedge clk);
      check_eq("stray_r_rsp_valid", rsp_valid, 0);
      check_eq("stray_r_busy", busy, 0);
    end
    run_txn(0, 8'h1C, 32'h0, 4'h0, 0, "rd_after_stray");

`ifdef AXI4_LITE_CSR_MASTER_TIMEOUT_EN
    ar_block = 1;
    run_txn(0, 8'h30, 32'h0, 4'h0, 0, "rd_timeout");
    check_eq("rd_timeout_ar_cycles", ar_hi, TO);
    ar_block = 0;
    run_txn(0, 8'h30, 32'h0, 4'h0, 0, "rd_after_timeout");
`endif

    // Reset in the middle of a write whose AW is still stalled.
    aw_dly = 10;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h40; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check_eq("midrst_awvalid", csr_if.awvalid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    aw_dly = 0;
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_no_rsp", rsp_valid, 0);
    end
    run_txn(0, 8'h40, 32'h0, 4'h0, 0, "rd_after_midrst");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 63)) << 2;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = resp_tbl[$urandom_range(0, 3)];
      rresp_cfg = resp_tbl[$urandom_range(0, 3)];
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
